regfile_sb: RTL and testbench

- Parametrised integer register file for the RISC-V core, generalising the current 2R1W file to NRD read ports.
- Forwarding is correct on every read port independently: a write matching several read addresses bypasses to all of them.
- Adds a per-register pending-write scoreboard. Issue marks a destination busy and writeback clears it. Decode uses the per-port busy flags to stall on RAW hazards.
- Sits between decode/issue (read, issue) and writeback (write).

---
 rtl/regfile_sb.sv | 76 +++++++
 tb/tb_regfile_sb.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Integer register file with NRD combinational read ports, per-port write bypass,
// and a per-register pending-write scoreboard for RAW hazard stalls.
module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int AW       = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    output logic                any_busy
);

    localparam bit ZR = (ZERO_REG != 0);

    logic [XLEN-1:0]  mem_reg [NREGS];
    logic [NREGS-1:0] pending_reg;
    logic [NREGS-1:0] pending_next;
    logic             wr_eff;
    logic             iss_eff;

    assign wr_eff  = wr_en  && !(ZR && (wr_addr  == '0));
    assign iss_eff = iss_en && !(ZR && (iss_addr == '0));

    // Issue is applied after the clear so a same-address collision stays pending:
    // the write belongs to an older instruction than the one now issuing.
    always_comb begin
        pending_next = pending_reg;
        if (wr_eff)
            pending_next[wr_addr] = 1'b0;
        if (iss_eff)
            pending_next[iss_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                mem_reg[i] <= '0;
            pending_reg <= '0;
        end else begin
            if (wr_eff)
                mem_reg[wr_addr] <= wr_data;
            pending_reg <= pending_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_port
            logic [AW-1:0] addr;
            logic          is_zero;
            logic          hit;

            assign addr    = rd_addr[gi*AW +: AW];
            assign is_zero = ZR && (addr == '0);
            assign hit     = wr_eff && (wr_addr == addr);

            assign rd_data[gi*XLEN +: XLEN] = is_zero ? '0 :
                                              hit     ? wr_data : mem_reg[addr];
            // A writeback landing this cycle resolves the hazard immediately.
            assign rd_busy[gi] = !is_zero && pending_reg[addr] && !hit;
        end
    endgenerate

    assign any_busy = |pending_reg;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed checks on a 3-port RV32 configuration plus a randomised model
// comparison on a 64-bit, 16-register, 4-port configuration without a zero register.
module tb_regfile_sb;

    logic clk;
    int   total;
    int   bad;

    // Configuration A: XLEN=32, NREGS=32, NRD=3, ZERO_REG=1
    logic        a_rst, a_wr_en, a_iss_en;
    logic [4:0]  a_wr_addr, a_iss_addr;
    logic [31:0] a_wr_data;
    logic [14:0] a_rd_addr;
    logic [95:0] a_rd_data;
    logic [2:0]  a_rd_busy;
    logic        a_any_busy;

    // Configuration B: XLEN=64, NREGS=16, NRD=4, ZERO_REG=0
    logic         b_rst, b_wr_en, b_iss_en;
    logic [3:0]   b_wr_addr, b_iss_addr;
    logic [63:0]  b_wr_data;
    logic [15:0]  b_rd_addr;
    logic [255:0] b_rd_data;
    logic [3:0]   b_rd_busy;
    logic         b_any_busy;

    regfile_sb #(.XLEN(32), .NREGS(32), .NRD(3), .ZERO_REG(1)) dut_a (
        .clk(clk), .rst(a_rst),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .iss_en(a_iss_en), .iss_addr(a_iss_addr),
        .rd_addr(a_rd_addr), .rd_data(a_rd_data),
        .rd_busy(a_rd_busy), .any_busy(a_any_busy)
    );

    regfile_sb #(.XLEN(64), .NREGS(16), .NRD(4), .ZERO_REG(0)) dut_b (
        .clk(clk), .rst(b_rst),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .iss_en(b_iss_en), .iss_addr(b_iss_addr),
        .rd_addr(b_rd_addr), .rd_data(b_rd_data),
        .rd_busy(b_rd_busy), .any_busy(b_any_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge; checks happen at the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic a_idle();
        a_wr_en = 1'b0; a_iss_en = 1'b0; a_rst = 1'b0;
    endtask

    task automatic a_set_rd(input int p, input logic [4:0] ad);
        a_rd_addr[p*5 +: 5] = ad;
    endtask

    function automatic logic [31:0] a_rd(input int p);
        return a_rd_data[p*32 +: 32];
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic test_reset();
        a_idle();
        a_wr_en = 1'b1; a_wr_addr = 5'd5; a_wr_data = 32'hDEADBEEF;
        step();
        a_idle();
        a_iss_en = 1'b1; a_iss_addr = 5'd7;
        a_set_rd(0, 5'd5);
        settle();
        chk32("reset_pre_x5", a_rd(0), 32'hDEADBEEF);
        step();
        a_idle();
        a_rst = 1'b1;
        a_wr_en = 1'b1; a_wr_addr = 5'd6; a_wr_data = 32'h77;
        a_iss_en = 1'b1; a_iss_addr = 5'd8;
        step();
        a_idle();
        a_set_rd(0, 5'd5); a_set_rd(1, 5'd6); a_set_rd(2, 5'd7);
        settle();
        chk32("reset_x5", a_rd(0), 32'h0);
        chk32("reset_x6_ignored_wr", a_rd(1), 32'h0);
        chk32("reset_x7", a_rd(2), 32'h0);
        chk32("reset_busy", {29'd0, a_rd_busy}, 32'h0);
        chk32("reset_any_busy", {31'd0, a_any_busy}, 32'h0);
        a_set_rd(2, 5'd8);
        settle();
        chk32("reset_iss_ignored", {31'd0, a_rd_busy[2]}, 32'h0);
        $display("reset: x5/x6/x7 cleared, pending cleared");
    endtask

    task automatic test_forward();
        a_idle();
        a_set_rd(0, 5'd7); a_set_rd(1, 5'd7); a_set_rd(2, 5'd7);
        a_wr_en = 1'b1; a_wr_addr = 5'd7; a_wr_data = 32'h12345678;
        settle();
        for (int p = 0; p < 3; p++)
            chk32($sformatf("fwd_port%0d", p), a_rd(p), 32'h12345678);
        step();
        a_idle();
        settle();
        for (int p = 0; p < 3; p++)
            chk32($sformatf("fwd_array_port%0d", p), a_rd(p), 32'h12345678);
        $display("forward: x7=0x12345678 on 3 ports");
    endtask

    task automatic test_zero_reg();
        a_idle();
        a_set_rd(0, 5'd0);
        a_wr_en = 1'b1; a_wr_addr = 5'd0; a_wr_data = 32'hFFFFFFFF;
        a_iss_en = 1'b1; a_iss_addr = 5'd0;
        settle();
        chk32("zero_bypass", a_rd(0), 32'h0);
        chk32("zero_busy_same", {31'd0, a_rd_busy[0]}, 32'h0);
        step();
        a_idle();
        settle();
        chk32("zero_array", a_rd(0), 32'h0);
        chk32("zero_busy_next", {31'd0, a_rd_busy[0]}, 32'h0);
        chk32("zero_any_busy", {31'd0, a_any_busy}, 32'h0);
        $display("zero_reg: x0 write/issue suppressed");
    endtask

    task automatic test_scoreboard();
        a_idle();
        a_set_rd(0, 5'd3); a_set_rd(1, 5'd3); a_set_rd(2, 5'd2);
        a_iss_en = 1'b1; a_iss_addr = 5'd3;
        settle();
        chk32("sb_issue_same_cycle", {31'd0, a_rd_busy[0]}, 32'h0);
        step();
        a_idle();
        settle();
        chk32("sb_busy_n1", {29'd0, a_rd_busy}, 32'h3);
        chk32("sb_any_n1", {31'd0, a_any_busy}, 32'h1);
        step();
        step();
        step();
        a_wr_en = 1'b1; a_wr_addr = 5'd3; a_wr_data = 32'hAA;
        settle();
        chk32("sb_busy_n4", {29'd0, a_rd_busy}, 32'h0);
        chk32("sb_data_n4", a_rd(0), 32'hAA);
        chk32("sb_any_n4", {31'd0, a_any_busy}, 32'h1);
        step();
        a_idle();
        settle();
        chk32("sb_busy_n5", {31'd0, a_rd_busy[0]}, 32'h0);
        chk32("sb_any_n5", {31'd0, a_any_busy}, 32'h0);
        chk32("sb_data_n5", a_rd(0), 32'hAA);
        $display("scoreboard: x3 issued, busy 4 cycles, written 0xAA");
    endtask

    task automatic test_collision();
        a_idle();
        a_iss_en = 1'b1; a_iss_addr = 5'd9;
        step();
        a_idle();
        a_set_rd(0, 5'd9);
        a_iss_en = 1'b1; a_iss_addr = 5'd9;
        a_wr_en = 1'b1; a_wr_addr = 5'd9; a_wr_data = 32'h55;
        settle();
        chk32("coll_busy_same", {31'd0, a_rd_busy[0]}, 32'h0);
        chk32("coll_data_same", a_rd(0), 32'h55);
        step();
        a_idle();
        settle();
        chk32("coll_data_next", a_rd(0), 32'h55);
        chk32("coll_busy_next", {31'd0, a_rd_busy[0]}, 32'h1);
        a_wr_en = 1'b1; a_wr_addr = 5'd9; a_wr_data = 32'h56;
        step();
        a_idle();
        a_iss_en = 1'b1; a_iss_addr = 5'd4;
        a_wr_en = 1'b1; a_wr_addr = 5'd6; a_wr_data = 32'h66;
        step();
        a_idle();
        a_set_rd(0, 5'd4); a_set_rd(1, 5'd6); a_set_rd(2, 5'd9);
        settle();
        chk32("split_busy", {29'd0, a_rd_busy}, 32'h1);
        chk32("split_x6", a_rd(1), 32'h66);
        chk32("split_x9", a_rd(2), 32'h56);
        chk32("split_any", {31'd0, a_any_busy}, 32'h1);
        a_wr_en = 1'b1; a_wr_addr = 5'd4; a_wr_data = 32'h44;
        step();
        a_idle();
        settle();
        chk32("split_clear_any", {31'd0, a_any_busy}, 32'h0);
        $display("collision: x9 stays pending with 0x55; x4 busy, x6 clear");
    endtask

    task automatic test_sweep();
        logic [63:0] m_mem [16];
        logic [15:0] m_pend;
        logic [63:0] exp_d;
        logic        exp_b;
        logic [3:0]  ra;
        int          errs;

        // Directed: x0 is an ordinary register in this configuration
        b_rst = 1'b0; b_wr_en = 1'b0;
        b_iss_en = 1'b1; b_iss_addr = 4'd0;
        b_rd_addr = 16'h0000;
        step();
        b_iss_en = 1'b0;
        settle();
        chk32("sweep_x0_busy", {28'd0, b_rd_busy}, 32'hF);
        chk32("sweep_x0_any", {31'd0, b_any_busy}, 32'h1);
        b_wr_en = 1'b1; b_wr_addr = 4'd0; b_wr_data = 64'hCAFE_F00D_0123_4567;
        step();
        b_wr_en = 1'b0;
        settle();
        chk32("sweep_x0_lo", b_rd_data[31:0], 32'h01234567);
        chk32("sweep_x0_hi", b_rd_data[63:32], 32'hCAFEF00D);
        chk32("sweep_x0_cleared", {27'd0, b_rd_busy, b_any_busy}, 32'h0);

        for (int i = 0; i < 16; i++) m_mem[i] = 64'd0;
        m_mem[0] = 64'hCAFE_F00D_0123_4567;
        m_pend = '0;
        errs = 0;

        for (int cyc = 0; cyc < 10000; cyc++) begin
            b_rst      = ($urandom_range(0, 999) == 0);
            b_wr_en    = ($urandom_range(0, 1) == 1);
            b_wr_addr  = 4'($urandom_range(0, 15));
            b_wr_data  = {$urandom, $urandom};
            b_iss_en   = ($urandom_range(0, 2) != 0);
            b_iss_addr = 4'($urandom_range(0, 15));
            for (int p = 0; p < 4; p++)
                b_rd_addr[p*4 +: 4] = ($urandom_range(0, 3) == 0) ? b_wr_addr
                                                                   : 4'($urandom_range(0, 15));
            settle();
            if (!b_rst) begin
                for (int p = 0; p < 4; p++) begin
                    ra = b_rd_addr[p*4 +: 4];
                    exp_d = (b_wr_en && b_wr_addr == ra) ? b_wr_data : m_mem[ra];
                    exp_b = m_pend[ra] && !(b_wr_en && b_wr_addr == ra);
                    total++;
                    if (b_rd_data[p*64 +: 64] !== exp_d) begin
                        bad++; errs++;
                        $display("FAIL sweep_data cyc=%0d port=%0d x%0d: got 0x%016h expected 0x%016h",
                                 cyc, p, ra, b_rd_data[p*64 +: 64], exp_d);
                    end
                    total++;
                    if (b_rd_busy[p] !== exp_b) begin
                        bad++; errs++;
                        $display("FAIL sweep_busy cyc=%0d port=%0d x%0d: got %0b expected %0b",
                                 cyc, p, ra, b_rd_busy[p], exp_b);
                    end
                end
                total++;
                if (b_any_busy !== (|m_pend)) begin
                    bad++; errs++;
                    $display("FAIL sweep_any cyc=%0d: got %0b expected %0b",
                             cyc, b_any_busy, |m_pend);
                end
            end
            step();
            if (b_rst) begin
                for (int i = 0; i < 16; i++) m_mem[i] = 64'd0;
                m_pend = '0;
            end else begin
                if (b_wr_en) begin
                    m_mem[b_wr_addr] = b_wr_data;
                    m_pend[b_wr_addr] = 1'b0;
                end
                if (b_iss_en)
                    m_pend[b_iss_addr] = 1'b1;
            end
        end
        b_rst = 1'b0; b_wr_en = 1'b0; b_iss_en = 1'b0;
        $display("sweep: 10000 random cycles, %0d errors", errs);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        a_rst = 1'b1; a_wr_en = 1'b0; a_iss_en = 1'b0;
        a_wr_addr = '0; a_wr_data = '0; a_iss_addr = '0; a_rd_addr = '0;
        b_rst = 1'b1; b_wr_en = 1'b0; b_iss_en = 1'b0;
        b_wr_addr = '0; b_wr_data = '0; b_iss_addr = '0; b_rd_addr = '0;
        step();
        step();
        a_rst = 1'b0;
        b_rst = 1'b0;

        test_reset();
        test_forward();
        test_zero_reg();
        test_scoreboard();
        test_collision();
        test_sweep();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
